// File: rtl/accum_window_if.sv
// accum_window_if
//   Groups the sample handshake and result bus of accum_window.
//   master: the sample source / result consumer (drives start, in_valid, in_data).
//   slave : the accumulator itself.
//   Signals:
//     start     begin (or restart) a window, level sampled each edge
//     in_valid  in_data is valid this cycle
//     in_data   unsigned sample, DW bits
//     in_ready  accumulator takes a sample this cycle
//     busy      accumulator is collecting a window
//     count     samples accepted in the current window, N_LOG2+1 bits
//     sum       accumulated sum, SW bits
//     avg       sum >> N_LOG2, DW bits
//     out_valid one-cycle pulse when sum/avg are final
//     ovf       sticky carry-out flag for the current window
interface accum_window_if #(
  parameter int DW     = 8,
  parameter int SW     = 16,
  parameter int N_LOG2 = 3
);
  logic              start;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              busy;
  logic [N_LOG2:0]   count;
  logic [SW-1:0]     sum;
  logic [DW-1:0]     avg;
  logic              out_valid;
  logic              ovf;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, busy, count, sum, avg, out_valid, ovf
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, busy, count, sum, avg, out_valid, ovf
  );
endinterface

// File: rtl/accum_window.sv
// accum_window
//   Windowed accumulator/averager. After start, sums exactly 2^N_LOG2 accepted
//   samples, then pulses out_valid for one cycle with the final sum and mean.
//   sum, avg, count and ovf hold until the next start or reset.
// Ports:
//   c      clock, rising edge
//   clr_n  synchronous active-low reset, dominates all other inputs
//   bus    accum_window_if.slave (handshake inputs, result outputs)
// Configuration:
//   ACCUM_WINDOW_SAT_EN  defined: sum clamps to all-ones on carry-out;
//                        undefined: sum wraps modulo 2^SW. ovf is set either way.
module accum_window #(
  parameter int DW     = 8,
  parameter int SW     = 16,
  parameter int N_LOG2 = 3
) (
  input logic           c,
  input logic           clr_n,
  accum_window_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Adder wide enough for both operands plus a carry bit.
  localparam int AW = ((SW > DW) ? SW : DW) + 1;

  // Count value just before the final sample of a window is accepted.
  localparam logic [N_LOG2:0] CNT_LAST = {1'b0, {N_LOG2{1'b1}}};

  logic [1:0]        r_state;
  logic [SW-1:0]     r_sum;
  logic [DW-1:0]     r_avg;
  logic [N_LOG2:0]   r_count;
  logic              r_ovf;

  logic              w_accept;
  logic [AW-1:0]     w_sum_ext;
  logic              w_carry;
  logic [SW-1:0]     w_sum_next;
  logic [DW-1:0]     w_avg_next;

  assign w_accept = bus.in_valid & (r_state == S_ACC);

  // Next sum with carry detection and wrap/clamp policy, plus mean of that sum.
  always_comb begin
    w_sum_ext = AW'(r_sum) + AW'(bus.in_data);
    w_carry   = |w_sum_ext[AW-1:SW];
`ifdef ACCUM_WINDOW_SAT_EN
    // Once clamped, any further non-zero sample carries again, so the clamp holds.
    if (w_carry) begin
      w_sum_next = {SW{1'b1}};
    end else begin
      w_sum_next = w_sum_ext[SW-1:0];
    end
`else
    w_sum_next = w_sum_ext[SW-1:0];
`endif
    // Widening before the shift zero-pads avg when SW - N_LOG2 < DW.
    w_avg_next = DW'(AW'(w_sum_next) >> N_LOG2);
  end

  // Window FSM and result registers.
  always_ff @(posedge c) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_sum   <= {SW{1'b0}};
      r_avg   <= {DW{1'b0}};
      r_count <= {(N_LOG2+1){1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ACC;
            r_sum   <= {SW{1'b0}};
            r_count <= {(N_LOG2+1){1'b0}};
            r_ovf   <= 1'b0;
          end
        end
        S_ACC: begin
          if (bus.start) begin
            // Restart: the sample offered in this cycle is dropped.
            r_sum   <= {SW{1'b0}};
            r_count <= {(N_LOG2+1){1'b0}};
            r_ovf   <= 1'b0;
          end else if (w_accept) begin
            r_sum   <= w_sum_next;
            r_count <= r_count + {{N_LOG2{1'b0}}, 1'b1};
            r_ovf   <= r_ovf | w_carry;
            if (r_count == CNT_LAST) begin
              r_avg   <= w_avg_next;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.start) begin
            r_state <= S_ACC;
            r_sum   <= {SW{1'b0}};
            r_count <= {(N_LOG2+1){1'b0}};
            r_ovf   <= 1'b0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_ACC);
  assign bus.busy      = (r_state == S_ACC);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.count     = r_count;
  assign bus.sum       = r_sum;
  assign bus.avg       = r_avg;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_accum_window.sv
// tb_accum_window
//   Self-checking bench for accum_window: directed scenarios with fixed
//   expectations plus a randomized run against a queue-based window model.
//   A second instance with SW=10 exercises carry-out (ACCUM_WINDOW_SAT_EN aware).
module tb_accum_window;
  localparam int DW     = 8;
  localparam int SW     = 16;
  localparam int SW10   = 10;
  localparam int N_LOG2 = 3;
  localparam int WIN    = 8;

  logic c = 1'b0;
  logic clr_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  accum_window_if #(.DW(DW), .SW(SW),   .N_LOG2(N_LOG2)) bus();
  accum_window_if #(.DW(DW), .SW(SW10), .N_LOG2(N_LOG2)) bus10();

  accum_window #(.DW(DW), .SW(SW), .N_LOG2(N_LOG2)) u_dut (
    .c(c), .clr_n(clr_n), .bus(bus)
  );
  accum_window #(.DW(DW), .SW(SW10), .N_LOG2(N_LOG2)) u_dut10 (
    .c(c), .clr_n(clr_n), .bus(bus10)
  );

  always #5 c = ~c;

  // Reference model of the default instance: the accepted samples of the
  // current window, whether a window is being collected, and the done pulse.
  int unsigned m_q[$];
  bit          m_collecting = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_avg = 0;

  function automatic int unsigned model_sum(input int unsigned q[$], input int sw);
    int unsigned total = 0;
    int unsigned maxv = (32'd1 << sw) - 32'd1;
    foreach (q[i]) total += q[i];
    if (total > maxv) begin
`ifdef ACCUM_WINDOW_SAT_EN
      return maxv;
`else
      return total % (maxv + 32'd1);
`endif
    end
    return total;
  endfunction

  function automatic bit model_ovf(input int unsigned q[$], input int sw);
    int unsigned total = 0;
    foreach (q[i]) total += q[i];
    return total > ((32'd1 << sw) - 32'd1);
  endfunction

  // Apply inputs to the default instance for one edge, advance the model, end at negedge.
  task automatic step(input bit st, input bit v, input logic [DW-1:0] d);
    bus.start = st; bus.in_valid = v; bus.in_data = d;
    @(posedge c);
    if (!clr_n) begin
      m_collecting = 1'b0; m_done = 1'b0; m_q.delete(); m_avg = 0;
    end else begin
      m_done = 1'b0;
      if (m_collecting) begin
        if (st) m_q.delete();
        else if (v) begin
          m_q.push_back(int'(d));
          if (m_q.size() == WIN) begin
            m_avg = (model_sum(m_q, SW) >> N_LOG2) & 32'hFF;
            m_collecting = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (st) begin
        m_collecting = 1'b1;
        m_q.delete();
      end
    end
    @(negedge c);
  endtask

  task automatic test_reset();
    logic [31:0] got;
    clr_n = 1'b0;
    bus10.start = 1'b1; bus10.in_valid = 1'b1; bus10.in_data = 8'hA5;
    step(1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 8'hA5);
    got = {bus.in_ready, bus.busy, bus.count, bus.sum, bus.avg, bus.out_valid, bus.ovf};
    checks++;
    if (got !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", got, 32'h0);
    end
    got = 32'({bus10.in_ready, bus10.busy, bus10.count, bus10.sum, bus10.avg, bus10.out_valid, bus10.ovf});
    checks++;
    if (got !== 32'h0) begin
      errors++; $display("FAIL reset_outputs_sw10: got %h expected %h", got, 32'h0);
    end
    clr_n = 1'b1;
    bus10.start = 1'b0; bus10.in_valid = 1'b0; bus10.in_data = 8'h00;
    step(1'b0, 1'b1, 8'h11);
    checks++;
    if ({bus.busy, bus.count, bus.sum} !== 21'h0) begin
      errors++; $display("FAIL idle_ignores_valid: got %h expected %h", {bus.busy, bus.count, bus.sum}, 21'h0);
    end
  endtask

  task automatic test_defaults();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'(i));
      if (i == 7) begin
        checks++;
        if (bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL early_out_valid: got %b expected %b", bus.out_valid, 1'b0);
        end
      end
    end
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.ovf} !== 3'b100) begin
      errors++; $display("FAIL done_flags: got %b expected %b", {bus.out_valid, bus.in_ready, bus.ovf}, 3'b100);
    end
    checks++;
    if ({bus.sum, bus.avg, bus.count} !== {16'd36, 8'd4, 4'd8}) begin
      errors++; $display("FAIL default_result: got sum=%0d avg=%0d count=%0d expected 36 4 8", bus.sum, bus.avg, bus.count);
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if ({bus.out_valid, bus.busy, bus.sum} !== {1'b0, 1'b0, 16'd36}) begin
      errors++; $display("FAIL hold_after_done: got ov=%b busy=%b sum=%0d expected 0 0 36", bus.out_valid, bus.busy, bus.sum);
    end
  endtask

  task automatic test_gapped();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL gapped_ready cycle %0d: got %b expected %b", i, bus.in_ready, 1'b1);
      end
      step(1'b0, 1'(i % 2), 8'hFF);
    end
    checks++;
    if ({bus.out_valid, bus.sum, bus.avg} !== {1'b1, 16'h07F8, 8'hFF}) begin
      errors++; $display("FAIL gapped_result: got ov=%b sum=%h avg=%h expected 1 07f8 ff", bus.out_valid, bus.sum, bus.avg);
    end
  endtask

  task automatic test_restart();
    step(1'b1, 1'b0, 8'h00);
    repeat (3) step(1'b0, 1'b1, 8'd5);
    checks++;
    if ({bus.count, bus.sum} !== {4'd3, 16'd15}) begin
      errors++; $display("FAIL partial_window: got count=%0d sum=%0d expected 3 15", bus.count, bus.sum);
    end
    step(1'b1, 1'b1, 8'd9);
    checks++;
    if ({bus.count, bus.sum, bus.busy} !== {4'd0, 16'd0, 1'b1}) begin
      errors++; $display("FAIL restart_clear: got count=%0d sum=%0d busy=%b expected 0 0 1", bus.count, bus.sum, bus.busy);
    end
    repeat (8) step(1'b0, 1'b1, 8'd2);
    checks++;
    if ({bus.out_valid, bus.sum, bus.avg} !== {1'b1, 16'd16, 8'd2}) begin
      errors++; $display("FAIL restart_result: got ov=%b sum=%0d avg=%0d expected 1 16 2", bus.out_valid, bus.sum, bus.avg);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 8'h00);
    repeat (8) step(1'b0, 1'b1, 8'd3);
    // start while the done pulse is up: new window, sample not taken
    step(1'b1, 1'b1, 8'd7);
    checks++;
    if ({bus.busy, bus.out_valid, bus.count, bus.sum} !== {1'b1, 1'b0, 4'd0, 16'd0}) begin
      errors++; $display("FAIL done_restart: got busy=%b ov=%b count=%0d sum=%0d expected 1 0 0 0", bus.busy, bus.out_valid, bus.count, bus.sum);
    end
    repeat (8) step(1'b0, 1'b1, 8'd7);
    checks++;
    if ({bus.out_valid, bus.sum, bus.avg} !== {1'b1, 16'd56, 8'd7}) begin
      errors++; $display("FAIL back_to_back_result: got ov=%b sum=%0d avg=%0d expected 1 56 7", bus.out_valid, bus.sum, bus.avg);
    end
  endtask

  task automatic test_overflow();
    logic [SW10-1:0] exp_sum;
`ifdef ACCUM_WINDOW_SAT_EN
    exp_sum = 10'h3FF;
`else
    exp_sum = 10'h3F8;
`endif
    bus10.start = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    bus10.start = 1'b0; bus10.in_valid = 1'b1; bus10.in_data = 8'hFF;
    repeat (4) step(1'b0, 1'b0, 8'h00);
    checks++;
    if ({bus10.ovf, bus10.sum} !== {1'b0, 10'h3FC}) begin
      errors++; $display("FAIL pre_carry: got ovf=%b sum=%h expected 0 3fc", bus10.ovf, bus10.sum);
    end
    repeat (4) step(1'b0, 1'b0, 8'h00);
    bus10.in_valid = 1'b0;
    checks++;
    if ({bus10.out_valid, bus10.ovf, bus10.sum, bus10.avg} !== {1'b1, 1'b1, exp_sum, 8'h7F}) begin
      errors++; $display("FAIL overflow_result: got ov=%b ovf=%b sum=%h avg=%h expected 1 1 %h 7f", bus10.out_valid, bus10.ovf, bus10.sum, bus10.avg, exp_sum);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 8'h00);
    repeat (5) step(1'b0, 1'b1, 8'd3);
    checks++;
    if (bus.count !== 4'd5) begin
      errors++; $display("FAIL mid_count: got %0d expected %0d", bus.count, 5);
    end
    clr_n = 1'b0;
    step(1'b0, 1'b1, 8'd3);
    checks++;
    if ({bus.busy, bus.in_ready, bus.out_valid, bus.count, bus.sum} !== 23'h0) begin
      errors++; $display("FAIL mid_reset: got busy=%b rdy=%b ov=%b count=%0d sum=%0d expected all 0", bus.busy, bus.in_ready, bus.out_valid, bus.count, bus.sum);
    end
    clr_n = 1'b1;
    step(1'b0, 1'b1, 8'd3);
    checks++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL no_pulse_after_reset: got %b expected %b", {bus.out_valid, bus.busy}, 2'b00);
    end
  endtask

  task automatic test_random();
    logic [N_LOG2:0] e_cnt;
    logic [SW-1:0]   e_sum;
    logic [DW-1:0]   e_avg;
    int              tmp;
    for (int cyc = 0; cyc < 600; cyc++) begin
      clr_n = ($urandom_range(0, 149) != 0);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
           ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      tmp   = m_q.size();
      e_cnt = tmp[N_LOG2:0];
      e_sum = SW'(model_sum(m_q, SW));
      e_avg = DW'(m_avg);
      checks++;
      if ({bus.in_ready, bus.busy, bus.out_valid} !== {m_collecting, m_collecting, m_done}) begin
        errors++; $display("FAIL rand_ctrl cycle %0d: got %b expected %b", cyc, {bus.in_ready, bus.busy, bus.out_valid}, {m_collecting, m_collecting, m_done});
      end
      checks++;
      if ({bus.count, bus.sum, bus.ovf} !== {e_cnt, e_sum, model_ovf(m_q, SW)}) begin
        errors++; $display("FAIL rand_sum cycle %0d: got count=%0d sum=%0d ovf=%b expected %0d %0d %b", cyc, bus.count, bus.sum, bus.ovf, e_cnt, e_sum, model_ovf(m_q, SW));
      end
      checks++;
      if (bus.avg !== e_avg) begin
        errors++; $display("FAIL rand_avg cycle %0d: got %0d expected %0d", cyc, bus.avg, e_avg);
      end
    end
    clr_n = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    bus10.start = 1'b0; bus10.in_valid = 1'b0; bus10.in_data = 8'h00;
    test_reset();
    test_defaults();
    test_gapped();
    test_restart();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
